// File: rtl/x_scale_pkg.sv
// Shared definitions for the horizontal scale-coordinate sequencer.
// Holds the default widths of the scale ROM and the sequencer state type.
package x_scale_pkg;

    localparam int unsigned X_ADDR_WIDTH = 11;
    localparam int unsigned X_DATA_WIDTH = 15;
    localparam int unsigned X_FRAC_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/x_scale_skid_fifo.sv
// Two-entry FIFO used to absorb ROM words while the coordinate consumer stalls.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   push, din     - write request and data (ignored when full unless popping)
//   pop, dout     - read request and head data (ignored when empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries (0..2)
module x_scale_skid_fifo
    import x_scale_pkg::*;
#(
    parameter int unsigned WIDTH = X_ADDR_WIDTH + X_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/x_scale_seq.sv
// Horizontal scale sequencer: walks output columns 0..out_width-1, reads the
// per-column source x position from a scale ROM (1-cycle latency) and streams
// {col, int, frac, last} coordinates through a valid/ready interface.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   line_start, out_width  - start one line of out_width columns (ignored while busy)
//   busy, line_done        - line in progress / single-cycle completion pulse
//   rom_addr, rom_rd_data  - scale ROM address and returned word
//   coord_valid/ready      - coordinate handshake
//   coord_col/int/frac/last- coordinate fields
module x_scale_seq
    import x_scale_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = X_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = X_DATA_WIDTH,
    parameter int unsigned FRAC_WIDTH = X_FRAC_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             line_start,
    input  logic [ADDR_WIDTH-1:0]            out_width,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            rom_addr,
    input  logic [DATA_WIDTH-1:0]            rom_rd_data,
    output logic                             coord_valid,
    input  logic                             coord_ready,
    output logic [ADDR_WIDTH-1:0]            coord_col,
    output logic [DATA_WIDTH-FRAC_WIDTH-1:0] coord_int,
    output logic [FRAC_WIDTH-1:0]            coord_frac,
    output logic                             coord_last,
    output logic                             line_done
);

    localparam int unsigned ENT_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   width_q, width_d;
    logic [ADDR_WIDTH-1:0]   infl_col_q, infl_col_d;
    logic                    infl_q, infl_d;
    logic                    infl_last_q, infl_last_d;
    logic                    line_done_q, line_done_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]              fifo_count;
    logic [ENT_WIDTH-1:0]    fifo_dout, bypass_ent, head;
    logic                    head_valid, head_last, hs;
    logic                    issue, issue_last, start_ok;
    logic [2:0]              occ;

    // Entry layout: {col, rom word, last}. The word arriving from the ROM this
    // cycle is presented directly when the FIFO is empty, which is what gives
    // coord_valid two cycles after line_start; it is only pushed if not taken.
    always_comb begin
        bypass_ent = {infl_col_q, rom_rd_data, infl_last_q};
        head       = fifo_empty ? bypass_ent : fifo_dout;
        head_valid = !fifo_empty || infl_q;
        head_last  = head[0];
        hs         = head_valid && coord_ready;
        fifo_pop   = hs && !fifo_empty;
        fifo_push  = infl_q && !(hs && fifo_empty) && (!fifo_full || fifo_pop);
        // Words held or in flight after this cycle's pop; a new read must fit in 2.
        occ        = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, hs};
        issue      = (state_q == ST_RUN) && (occ < 3'd2);
        issue_last = issue && (cnt_q == width_q - ONE);
        start_ok   = (state_q == ST_IDLE) && line_start;
    end

    x_scale_skid_fifo #(
        .WIDTH(ENT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bypass_ent),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (line_start && (out_width != '0)) state_d = ST_RUN;
            ST_RUN:   if (issue_last) state_d = ST_DRAIN;
            ST_DRAIN: if (hs && head_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Column counter and in-flight tracking
    always_comb begin
        cnt_d       = cnt_q;
        width_d     = width_q;
        if (start_ok) begin
            cnt_d   = '0;
            width_d = out_width;
        end else if (issue && !issue_last) begin
            // The counter parks on the last column so it never wraps.
            cnt_d   = cnt_q + ONE;
        end else if ((state_q == ST_DRAIN) && hs && head_last) begin
            cnt_d   = '0;
        end
        infl_d      = issue;
        infl_col_d  = issue ? cnt_q : infl_col_q;
        infl_last_d = issue ? issue_last : infl_last_q;
        line_done_d = (start_ok && (out_width == '0)) || (hs && head_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            width_q     <= '0;
            infl_q      <= 1'b0;
            infl_col_q  <= '0;
            infl_last_q <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            infl_q      <= infl_d;
            infl_col_q  <= infl_col_d;
            infl_last_q <= infl_last_d;
            line_done_q <= line_done_d;
        end
    end

    // Outputs
    always_comb begin
        busy        = (state_q != ST_IDLE);
        rom_addr    = (state_q != ST_IDLE) ? cnt_q : '0;
        coord_valid = head_valid;
        coord_col   = '0;
        coord_int   = '0;
        coord_frac  = '0;
        coord_last  = 1'b0;
        if (head_valid) begin
            coord_col  = head[ENT_WIDTH-1 -: ADDR_WIDTH];
            coord_int  = head[DATA_WIDTH : FRAC_WIDTH+1];
            coord_frac = head[FRAC_WIDTH : 1];
            coord_last = head[0];
        end
        line_done   = line_done_q;
    end

endmodule
